// File: rtl/mod_count_checker_pkg.sv
// mod_count_checker_pkg: shared state encodings, counter widths and the modulo-N next-value rule.
package mod_count_checker_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } state_t;
  localparam int ERR_W = 8;
  // Out-of-range v simply steps by one; the caller truncates to its count width.
  function automatic int next_val(input int v, input logic up, input int n);
    return up ? (v == n - 1 ? 0 : v + 1) : (v == 0 ? n - 1 : v - 1);
  endfunction
endpackage

// File: rtl/mod_count_checker_if.sv
// mod_count_checker_if: sample bus and status outputs between a counter-side master and the checker.
// Ports: sample_en/updown/count_in driven by master; locked/err/wrap/err_count/expected driven by the checker.
interface mod_count_checker_if #(parameter int WIDTH = 4);
  import mod_count_checker_pkg::*;
  logic             sample_en;
  logic             updown;
  logic [WIDTH-1:0] count_in;
  logic             locked;
  logic             err;
  logic             wrap;
  logic [ERR_W-1:0] err_count;
  logic [WIDTH-1:0] expected;
  modport master (output sample_en, updown, count_in, input locked, err, wrap, err_count, expected);
  modport slave  (input sample_en, updown, count_in, output locked, err, wrap, err_count, expected);
endinterface

// File: rtl/mod_next_value.sv
// mod_next_value: combinational modulo-N successor/predecessor of v_i.
// Ports: v_i value, up_i direction (1 = up), next_o predicted next value.
module mod_next_value
  import mod_count_checker_pkg::*;
#(
  parameter int N     = 12,
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] v_i,
  input  logic             up_i,
  output logic [WIDTH-1:0] next_o
);
  assign next_o = WIDTH'(next_val(int'(v_i), up_i, N));
endmodule

// File: rtl/mod_count_checker.sv
// mod_count_checker: checks that each sampled count is the modulo-N successor of the previous one.
// Ports: clk, rst_n (async active-low), bus (slave side of mod_count_checker_if).
module mod_count_checker
  import mod_count_checker_pkg::*;
#(
  parameter int N        = 12,
  parameter int WIDTH    = 4,
  parameter int LOCK_LEN = 4
) (
  input logic                clk,
  input logic                rst_n,
  mod_count_checker_if.slave bus
);
  localparam int RW = $clog2(LOCK_LEN + 1);
  localparam logic [WIDTH-1:0] NM1 = WIDTH'(N - 1);
  state_t           state_q, state_d;
  logic [RW-1:0]    run_q, run_d;
  logic [WIDTH-1:0] exp_q, exp_d, prev_q, prev_d, nxt;
  logic             prev_up_q, prev_up_d, err_q, err_d, wrap_q, wrap_d;
  logic [ERR_W-1:0] ec_q, ec_d;
  logic             in_rng, match, wrap_hit;
  mod_next_value #(.N(N), .WIDTH(WIDTH)) u_next (
    .v_i   (bus.count_in),
    .up_i  (bus.updown),
    .next_o(nxt)
  );
  assign in_rng   = bus.count_in <= NM1;
  assign match    = in_rng && bus.count_in == exp_q;
  // Wrap is judged from the previous sample and its direction, not from the prediction alone.
  assign wrap_hit = (prev_up_q && prev_q == NM1 && bus.count_in == '0) ||
                    (!prev_up_q && prev_q == '0 && bus.count_in == NM1);
  always_comb begin
    state_d   = state_q;
    run_d     = run_q;
    exp_d     = exp_q;
    prev_d    = prev_q;
    prev_up_d = prev_up_q;
    err_d     = 1'b0;
    wrap_d    = 1'b0;
    ec_d      = ec_q;
    if (bus.sample_en) begin
      exp_d     = nxt;
      prev_d    = bus.count_in;
      prev_up_d = bus.updown;
      case (state_q)
        // An out-of-range first sample gives nothing to predict from, so stay in IDLE.
        IDLE: begin
          run_d   = '0;
          state_d = in_rng ? ACQ : IDLE;
        end
        ACQ: begin
          run_d   = match ? run_q + 1'b1 : '0;
          state_d = match ? (run_q == RW'(LOCK_LEN - 1) ? LOCKED : ACQ) : (in_rng ? ACQ : IDLE);
        end
        LOCKED: begin
          wrap_d  = match && wrap_hit;
          err_d   = !match;
          ec_d    = (match || &ec_q) ? ec_q : ec_q + 1'b1;
          run_d   = '0;
          state_d = match ? LOCKED : (in_rng ? ACQ : IDLE);
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      run_q     <= '0;
      exp_q     <= '0;
      prev_q    <= '0;
      prev_up_q <= 1'b0;
      err_q     <= 1'b0;
      wrap_q    <= 1'b0;
      ec_q      <= '0;
    end else begin
      state_q   <= state_d;
      run_q     <= run_d;
      exp_q     <= exp_d;
      prev_q    <= prev_d;
      prev_up_q <= prev_up_d;
      err_q     <= err_d;
      wrap_q    <= wrap_d;
      ec_q      <= ec_d;
    end
  end
  assign bus.locked    = state_q == LOCKED;
  assign bus.err       = err_q;
  assign bus.wrap      = wrap_q;
  assign bus.err_count = ec_q;
  assign bus.expected  = exp_q;
endmodule

// File: tb/tb_mod_count_checker.sv
// tb_mod_count_checker: randomized and directed stimulus against a behavioural model of the checker.
module tb_mod_count_checker;
  localparam int N = 12, W = 4, LL = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0, failures = 0;
  mod_count_checker_if #(.WIDTH(W)) bus ();
  mod_count_checker #(.N(N), .WIDTH(W), .LOCK_LEN(LL)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  // model: mode 0 = idle, 1 = acquiring, 2 = locked
  int m_mode, m_run, m_exp, m_prev, m_ec;
  bit m_prev_up, m_err, m_wrap;
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask
  function automatic int succ(input int v, input bit up);
    if (up) return (v == N - 1) ? 0 : (v + 1) % (1 << W);
    return (v == 0) ? N - 1 : v - 1;
  endfunction
  task automatic m_reset();
    m_mode = 0; m_run = 0; m_exp = 0; m_prev = 0; m_prev_up = 0; m_ec = 0; m_err = 0; m_wrap = 0;
  endtask
  task automatic m_sample(input bit en, input bit up, input int v);
    bit good, wrapped;
    m_err = 0;
    m_wrap = 0;
    if (!en) return;
    good = v < N && v == m_exp;
    wrapped = (m_prev == N - 1 && m_prev_up && v == 0) || (m_prev == 0 && !m_prev_up && v == N - 1);
    if (m_mode == 0) begin
      m_mode = v < N ? 1 : 0;
      m_run = 0;
    end else if (good) begin
      if (m_mode == 2) m_wrap = wrapped;
      else begin
        m_run++;
        if (m_run == LL) m_mode = 2;
      end
    end else begin
      if (m_mode == 2) begin
        m_err = 1;
        if (m_ec < 255) m_ec++;
      end
      m_run = 0;
      m_mode = v < N ? 1 : 0;
    end
    m_exp = succ(v, up);
    m_prev = v;
    m_prev_up = up;
  endtask
  task automatic compare_all(input string ph);
    chk({ph, ".locked"}, int'(bus.locked), int'(m_mode == 2));
    chk({ph, ".err"}, int'(bus.err), int'(m_err));
    chk({ph, ".wrap"}, int'(bus.wrap), int'(m_wrap));
    chk({ph, ".err_count"}, int'(bus.err_count), m_ec);
    chk({ph, ".expected"}, int'(bus.expected), m_exp);
  endtask
  task automatic step(input string ph, input bit en, input bit up, input int v);
    @(negedge clk);
    bus.sample_en = en;
    bus.updown = up;
    bus.count_in = W'(v);
    @(posedge clk);
    m_sample(en, up, v);
    #1;
    compare_all(ph);
  endtask
  initial begin
    bit up;
    int v;
    int r;
    bus.sample_en = 0;
    bus.updown = 1;
    bus.count_in = '0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    compare_all("reset");
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i <= 4; i++) step("acq_up", 1, 1, i);
    chk("locked_after_4", int'(bus.locked), 1);
    for (int i = 5; i <= 11; i++) step("run_up", 1, 1, i);
    step("wrap_up", 1, 1, 0);
    chk("wrap_up_pulse", int'(bus.wrap), 1);
    step("turn", 1, 0, 1);
    step("down", 1, 0, 0);
    step("wrap_dn", 1, 0, 11);
    chk("wrap_dn_pulse", int'(bus.wrap), 1);
    for (int i = 10; i >= 5; i--) step("down2", 1, 0, i);
    for (int i = 4; i <= 4; i++) step("upturn", 1, 1, i);
    step("inject7", 1, 1, 7);
    chk("inject_err", int'(bus.err), 1);
    chk("inject_unlock", int'(bus.locked), 0);
    for (int i = 8; i <= 11; i++) step("relock", 1, 1, i);
    chk("relock_ec", int'(bus.err_count), 1);
    step("oor", 1, 1, 14);
    chk("oor_err", int'(bus.err), 1);
    for (int i = 3; i <= 7; i++) step("oor_relock", 1, 1, i);
    chk("oor_relocked", int'(bus.locked), 1);
    for (int g = 0; g < 3; g++) begin
      v = m_exp;
      step("pre_gap", 1, 1, v);
      repeat (3) step("gap", 0, $urandom_range(0, 1), $urandom_range(0, 15));
    end
    up = 1;
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      if ($urandom_range(0, 9) == 0) up = !up;
      if (r < 5) step("rnd_gap", 0, $urandom_range(0, 1), $urandom_range(0, 15));
      else if (r < 10) step("rnd_bad", 1, up, $urandom_range(0, 15));
      else step("rnd_ok", 1, up, m_mode == 0 ? $urandom_range(0, N - 1) : m_exp);
    end
    for (int i = 0; i < 300; i++) begin
      step("sat_bad", 1, 1, m_mode == 0 ? 0 : (m_exp + 5) % N);
      repeat (LL) step("sat_ok", 1, 1, m_exp);
    end
    chk("saturated", int'(bus.err_count), 255);
    step("mid", 1, 1, m_exp);
    @(negedge clk);
    #2 rst_n = 0;
    m_reset();
    #1;
    compare_all("async_rst");
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i <= LL; i++) step("reacq", 1, 0, (N - i) % N);
    chk("reacq_locked", int'(bus.locked), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mod_count_checker.md
# mod_count_checker

Sequence checker for the up/down modulo-N counter: it watches the counter's output and direction input cycle by cycle and confirms that each value is the correct modulo-N successor of the previous one. It sits beside the counter in the same clock domain and drives lock, error and wrap status for debug, bring-up and self-checking benches. Acquisition is automatic: it locks after a run of correct transitions and resynchronises after any error.

## Interface
- N, 12, counter modulus; legal values 0..N-1
- WIDTH, 4, count width; N <= 2**WIDTH
- LOCK_LEN, 4, consecutive correct transitions required to enter LOCKED (>= 1)
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low; asserted (0) forces reset state immediately
- sample_en  in  1  count_in/updown valid this cycle
- updown  in  1  direction applied by the counter at this edge: 1 = up, 0 = down
- count_in  in  WIDTH  counter output being checked
- locked  out  1  checker in LOCKED state
- err  out  1  one-cycle pulse: mismatch detected while LOCKED
- wrap  out  1  one-cycle pulse: correct wrap observed while LOCKED (N-1→0 up, 0→N-1 down)
- err_count  out  8  saturating mismatch count (LOCKED only), saturates at 255
- expected  out  WIDTH  value predicted for the next valid sample

## Operation
- next(v,up): up → (v==N-1 ? 0 : v+1); down → (v==0 ? N-1 : v-1); width-WIDTH arithmetic, no overflow past N-1.
- Prediction: on every valid sample, expected <= next(count_in, updown).
- A sample "matches" iff count_in == expected and count_in < N. Any count_in >= N is a mismatch.
- States: IDLE, ACQ, LOCKED.
- IDLE: first valid sample loads expected, run counter = 0, → ACQ. No err.
- ACQ: match → run+1; when run reaches LOCK_LEN → LOCKED. Mismatch → run = 0, stay ACQ, reload expected from this sample (if count_in >= N, → IDLE instead). No err in ACQ.
- LOCKED: match → stay; mismatch → err pulse, err_count+1 (saturating), run = 0, → ACQ, expected reloaded from offending sample (→ IDLE if out of range).
- wrap: pulse on a matching LOCKED sample where the previous sample was N-1 with updown=1 and this is 0, or previous 0 with updown=0 and this is N-1.
- sample_en=0: all state holds, no pulses, expected unchanged (gaps allowed).
- Direction change mid-stream is legal; prediction always uses updown of the previous valid sample.

## Timing
- Reset values: locked=0, err=0, wrap=0, err_count=0, expected=0, state IDLE, run=0.
- All outputs registered; err/wrap assert the cycle after the sample edge that caused them, for exactly one cycle.
- locked rises the cycle after the LOCK_LEN-th matching sample; falls the cycle after the first mismatch.
- Reset mid-operation: outputs return to reset values asynchronously; err_count cleared; reacquisition needs 1 + LOCK_LEN valid samples.
- Back-to-back mismatches: only the first (in LOCKED) pulses err; following ones occur in ACQ and are silent.

## Structure
- Shared package/include: state encodings (IDLE, ACQ, LOCKED as 2-bit localparams), err_count width (8), next-value function definition.
- One sub-module natural: mod_next_value (combinational next(v,up) for parameters N, WIDTH), reusable by the counter and its benches.
- Top holds FSM, run counter, expected register, saturating err_count, pulse registers.

## Test plan
- Reset held, then released with sample_en=1 and a clean up count 0,1,2,3,4 → locked=1 the cycle after sample 4 (N=12, LOCK_LEN=4); err_count=0.
- Locked up count through 10,11,0 → wrap pulses one cycle after sample 0; no err; then updown=0, sequence 1,0,11 → second wrap after 11.
- Locked, inject 7 where 5 is expected → err one cycle, err_count=1, locked=0; then 8,9,10,11 → relocked, err_count still 1.
- Locked, inject count_in=14 (out of range) → err, state IDLE; next samples 3,4,5,6,7 → relock after 7.
- Insert sample_en=0 gaps of 3 cycles in a locked stream → no err, expected unchanged across gap.
- Force 300 locked/mismatch cycles → err_count saturates at 255; assert reset=0 mid-stream → all outputs 0 immediately.
